// File: rtl/uart_pwm_cmd_ctrl.sv
// uart_pwm_cmd_ctrl: decodes 5-byte UART frames (A5 CH DH DL CK) into PWM
// duty-cycle writes with checksum, channel-range and inter-byte timeout checks.
//
// Ports:
//   clk, resetn          system clock, async active-low reset
//   rx_valid/rx_data     one-cycle received byte strobe and data
//   rx_break             UART BREAK flag, qualified by rx_valid
//   cfg_wr_en/ch/duty    held write request to the PWM block
//   cfg_ready            PWM block accepts the write when high with cfg_wr_en
//   frame_err            one-cycle pulse per rejected frame / overrun
//   err_count            saturating count of frame_err pulses
//   busy                 high whenever the decoder is not idle
module uart_pwm_cmd_ctrl #(
    parameter int NUM_CH         = 4,
    parameter int TIMEOUT_CYCLES = 27000
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      rx_valid,
    input  logic [7:0]                rx_data,
    input  logic                      rx_break,
    output logic                      cfg_wr_en,
    output logic [$clog2(NUM_CH)-1:0] cfg_ch,
    output logic [15:0]               cfg_duty,
    input  logic                      cfg_ready,
    output logic                      frame_err,
    output logic [7:0]                err_count,
    output logic                      busy
);

    localparam int CH_W  = $clog2(NUM_CH);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0] HDR = 8'hA5;

    typedef enum logic [2:0] {
        IDLE,
        GET_CH,
        GET_DH,
        GET_DL,
        GET_CK,
        WRITE
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        ch_q, ch_d;
    logic [7:0]        dh_q, dh_d;
    logic [7:0]        dl_q, dl_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              cfg_wr_en_q, cfg_wr_en_d;
    logic [CH_W-1:0]   cfg_ch_q, cfg_ch_d;
    logic [15:0]       cfg_duty_q, cfg_duty_d;
    logic              frame_err_q, frame_err_d;
    logic [7:0]        err_count_q, err_count_d;
    logic              busy_q, busy_d;

    logic ck_ok;
    logic ch_ok;
    logic timeout;

    assign ck_ok   = (rx_data == (ch_q ^ dh_q ^ dl_q));
    assign ch_ok   = ({24'd0, ch_q} < 32'(NUM_CH));
    assign timeout = (cnt_q == CNT_MAX);

    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        dh_d        = dh_q;
        dl_d        = dl_q;
        cnt_d       = '0;
        cfg_wr_en_d = cfg_wr_en_q;
        cfg_ch_d    = cfg_ch_q;
        cfg_duty_d  = cfg_duty_q;
        frame_err_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                // BREAK and non-header bytes are dropped silently here.
                if (rx_valid && !rx_break && rx_data == HDR) begin
                    state_d = GET_CH;
                end
            end
            GET_CH, GET_DH, GET_DL, GET_CK: begin
                if (rx_valid) begin
                    // A byte beats a timeout landing in the same cycle.
                    if (rx_break) begin
                        state_d     = IDLE;
                        frame_err_d = 1'b1;
                    end else begin
                        unique case (state_q)
                            GET_CH: begin
                                ch_d    = rx_data;
                                state_d = GET_DH;
                            end
                            GET_DH: begin
                                dh_d    = rx_data;
                                state_d = GET_DL;
                            end
                            GET_DL: begin
                                dl_d    = rx_data;
                                state_d = GET_CK;
                            end
                            default: begin
                                if (ck_ok && ch_ok) begin
                                    state_d     = WRITE;
                                    cfg_wr_en_d = 1'b1;
                                    cfg_ch_d    = ch_q[CH_W-1:0];
                                    cfg_duty_d  = {dh_q, dl_q};
                                end else begin
                                    state_d     = IDLE;
                                    frame_err_d = 1'b1;
                                end
                            end
                        endcase
                    end
                end else if (timeout) begin
                    state_d     = IDLE;
                    frame_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WRITE: begin
                // Bytes arriving while a write is pending are overruns;
                // the pending write itself is never cancelled.
                if (rx_valid) begin
                    frame_err_d = 1'b1;
                end
                if (cfg_ready) begin
                    state_d     = IDLE;
                    cfg_wr_en_d = 1'b0;
                end
            end
            default: begin
                state_d     = IDLE;
                cfg_wr_en_d = 1'b0;
            end
        endcase

        if (frame_err_d && err_count_q != 8'hFF) begin
            err_count_d = err_count_q + 8'd1;
        end else begin
            err_count_d = err_count_q;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            ch_q        <= '0;
            dh_q        <= '0;
            dl_q        <= '0;
            cnt_q       <= '0;
            cfg_wr_en_q <= 1'b0;
            cfg_ch_q    <= '0;
            cfg_duty_q  <= '0;
            frame_err_q <= 1'b0;
            err_count_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            dh_q        <= dh_d;
            dl_q        <= dl_d;
            cnt_q       <= cnt_d;
            cfg_wr_en_q <= cfg_wr_en_d;
            cfg_ch_q    <= cfg_ch_d;
            cfg_duty_q  <= cfg_duty_d;
            frame_err_q <= frame_err_d;
            err_count_q <= err_count_d;
            busy_q      <= busy_d;
        end
    end

    assign cfg_wr_en = cfg_wr_en_q;
    assign cfg_ch    = cfg_ch_q;
    assign cfg_duty  = cfg_duty_q;
    assign frame_err = frame_err_q;
    assign err_count = err_count_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_uart_pwm_cmd_ctrl.sv
// tb_uart_pwm_cmd_ctrl: directed bench for uart_pwm_cmd_ctrl.
// Expected writes are queued when frames are sent and popped on accept.
module tb_uart_pwm_cmd_ctrl;

    localparam int NUM_CH = 4;
    localparam int TO     = 100;
    localparam int CH_W   = $clog2(NUM_CH);

    logic            clk = 1'b0;
    logic            resetn;
    logic            rx_valid;
    logic [7:0]      rx_data;
    logic            rx_break;
    logic            cfg_wr_en;
    logic [CH_W-1:0] cfg_ch;
    logic [15:0]     cfg_duty;
    logic            cfg_ready;
    logic            frame_err;
    logic [7:0]      err_count;
    logic            busy;

    typedef struct {
        logic [CH_W-1:0] ch;
        logic [15:0]     duty;
    } wr_t;

    wr_t exp_q[$];
    int  passed  = 0;
    int  total   = 0;
    int  err_seen = 0;
    int  exp_err  = 0;
    int  wr_seen  = 0;
    int  exp_wr   = 0;

    uart_pwm_cmd_ctrl #(
        .NUM_CH(NUM_CH),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .rx_valid(rx_valid),
        .rx_data(rx_data),
        .rx_break(rx_break),
        .cfg_wr_en(cfg_wr_en),
        .cfg_ch(cfg_ch),
        .cfg_duty(cfg_duty),
        .cfg_ready(cfg_ready),
        .frame_err(frame_err),
        .err_count(err_count),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic send(input logic [7:0] b, input logic brk);
        rx_valid = 1'b1;
        rx_data  = b;
        rx_break = brk;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_break = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] c, input logic [7:0] dh,
                              input logic [7:0] dl, input logic [7:0] ck);
        send(8'hA5, 1'b0);
        send(c, 1'b0);
        send(dh, 1'b0);
        send(dl, 1'b0);
        send(ck, 1'b0);
    endtask

    task automatic expect_wr(input logic [CH_W-1:0] c, input logic [15:0] d);
        wr_t w;
        w.ch   = c;
        w.duty = d;
        exp_q.push_back(w);
        exp_wr++;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_wr_en"}, 32'(cfg_wr_en), 0);
        chk({tag, "_ferr"}, 32'(frame_err), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_ch"}, 32'(cfg_ch), 0);
        chk({tag, "_duty"}, 32'(cfg_duty), 0);
        chk({tag, "_errcnt"}, 32'(err_count), 0);
    endtask

    // Scoreboard: an accept happens on the edge after a negedge that
    // sees cfg_wr_en && cfg_ready.
    always @(negedge clk) begin
        if (resetn) begin
            if (frame_err) err_seen++;
            if (cfg_wr_en && cfg_ready) begin
                wr_t w;
                wr_seen++;
                chk("wr_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    w = exp_q.pop_front();
                    chk("wr_ch", 32'(cfg_ch), 32'(w.ch));
                    chk("wr_duty", 32'(cfg_duty), 32'(w.duty));
                end
            end
        end
    end

    initial begin
        int e0;
        resetn    = 1'b0;
        rx_valid  = 1'b0;
        rx_data   = 8'h00;
        rx_break  = 1'b0;
        cfg_ready = 1'b1;
        #1;
        chk_reset_outs("rst");
        cycles(3);
        resetn = 1'b1;
        cycles(2);

        // Good frame held off by cfg_ready for 10 cycles.
        cfg_ready = 1'b0;
        expect_wr(1, 16'h1234);
        send_frame(8'h01, 8'h12, 8'h34, 8'h27);
        chk("g1_wr_en", 32'(cfg_wr_en), 1);
        chk("g1_busy", 32'(busy), 1);
        for (int i = 0; i < 10; i++) begin
            cycles(1);
            chk("g1_hold_en", 32'(cfg_wr_en), 1);
            chk("g1_hold_ch", 32'(cfg_ch), 1);
            chk("g1_hold_duty", 32'(cfg_duty), 32'h1234);
        end
        chk("g1_no_early_wr", wr_seen, 0);
        cfg_ready = 1'b1;
        cycles(1);
        chk("g1_wr_drop", 32'(cfg_wr_en), 0);
        chk("g1_idle", 32'(busy), 0);
        chk("g1_one_wr", wr_seen, 1);

        // Bad checksum.
        send_frame(8'h01, 8'h12, 8'h34, 8'h00);
        exp_err++;
        chk("badck_ferr", 32'(frame_err), 1);
        chk("badck_cnt", 32'(err_count), 1);
        chk("badck_no_wr", 32'(cfg_wr_en), 0);
        cycles(1);
        chk("badck_pulse", 32'(frame_err), 0);

        // Channel out of range with a correct checksum.
        send_frame(8'h07, 8'h00, 8'h10, 8'h17);
        exp_err++;
        chk("badch_ferr", 32'(frame_err), 1);
        chk("badch_cnt", 32'(err_count), 2);
        chk("badch_no_wr", 32'(cfg_wr_en), 0);

        // BREAK mid-frame.
        send(8'hA5, 1'b0);
        send(8'h01, 1'b0);
        send(8'h12, 1'b1);
        exp_err++;
        chk("brk_ferr", 32'(frame_err), 1);
        chk("brk_busy", 32'(busy), 0);
        chk("brk_cnt", 32'(err_count), 3);

        // Inter-byte timeout.
        send(8'hA5, 1'b0);
        send(8'h02, 1'b0);
        cycles(TO - 1);
        chk("to_not_yet_busy", 32'(busy), 1);
        chk("to_not_yet_ferr", 32'(frame_err), 0);
        cycles(1);
        exp_err++;
        chk("to_ferr", 32'(frame_err), 1);
        chk("to_busy", 32'(busy), 0);
        chk("to_cnt", 32'(err_count), 4);

        // A byte arriving on the last counter value wins over the timeout.
        expect_wr(2, 16'h0005);
        send(8'hA5, 1'b0);
        send(8'h02, 1'b0);
        cycles(TO - 1);
        send(8'h00, 1'b0);
        chk("edge_no_ferr", 32'(frame_err), 0);
        chk("edge_busy", 32'(busy), 1);
        send(8'h05, 1'b0);
        send(8'h07, 1'b0);
        chk("edge_wr_en", 32'(cfg_wr_en), 1);
        chk("edge_cnt", 32'(err_count), 4);
        cycles(2);

        // Overrun during a pending write.
        cfg_ready = 1'b0;
        expect_wr(3, 16'hABCD);
        send_frame(8'h03, 8'hAB, 8'hCD, 8'h65);
        send(8'h55, 1'b0);
        exp_err++;
        chk("ovr_ferr", 32'(frame_err), 1);
        chk("ovr_wr_en", 32'(cfg_wr_en), 1);
        chk("ovr_ch", 32'(cfg_ch), 3);
        chk("ovr_duty", 32'(cfg_duty), 32'hABCD);
        chk("ovr_cnt", 32'(err_count), 5);
        cfg_ready = 1'b1;
        cycles(1);
        chk("ovr_done", 32'(cfg_wr_en), 0);

        // Junk and BREAK in IDLE are ignored.
        e0 = err_seen;
        send(8'h55, 1'b0);
        send(8'h00, 1'b0);
        send(8'hFF, 1'b0);
        send(8'hA5, 1'b1);
        cycles(2);
        chk("idle_no_ferr", err_seen - e0, 0);
        chk("idle_busy", 32'(busy), 0);
        chk("idle_cnt", 32'(err_count), 5);

        // Saturation of err_count.
        for (int i = 0; i < 300; i++) begin
            send_frame(8'h01, 8'h12, 8'h34, 8'h00);
            exp_err++;
        end
        cycles(1);
        chk("sat_cnt", 32'(err_count), 255);
        send_frame(8'h01, 8'h12, 8'h34, 8'h00);
        exp_err++;
        chk("sat_hold_ferr", 32'(frame_err), 1);
        chk("sat_hold_cnt", 32'(err_count), 255);
        cycles(2);

        // Reset during WRITE abandons the write.
        cfg_ready = 1'b0;
        send_frame(8'h01, 8'h00, 8'h01, 8'h00);
        chk("wrst_wr_en", 32'(cfg_wr_en), 1);
        resetn = 1'b0;
        #1;
        chk_reset_outs("wrst");
        cfg_ready = 1'b1;
        cycles(2);
        resetn = 1'b1;
        cycles(1);

        // Reset mid-frame, then the tail alone must not be decoded.
        send(8'hA5, 1'b0);
        send(8'h03, 1'b0);
        resetn = 1'b0;
        #1;
        chk_reset_outs("mrst");
        cycles(2);
        resetn = 1'b1;
        cycles(1);
        send(8'h00, 1'b0);
        send(8'h00, 1'b0);
        send(8'h05, 1'b0);
        send(8'h05, 1'b0);
        chk("mrst_tail_idle", 32'(busy), 0);
        expect_wr(0, 16'h0005);
        send_frame(8'h00, 8'h00, 8'h05, 8'h05);
        chk("mrst_wr_en", 32'(cfg_wr_en), 1);
        chk("mrst_ch", 32'(cfg_ch), 0);
        chk("mrst_duty", 32'(cfg_duty), 5);
        cycles(3);

        chk("end_q_empty", exp_q.size(), 0);
        chk("end_wr_total", wr_seen, exp_wr);
        chk("end_ferr_total", err_seen, exp_err);
        chk("end_errcnt", 32'(err_count), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
